if_fetch: RTL and testbench
===========================

Name: if_fetch

Overview:
- Instruction-fetch stage directly upstream of the decode stage, feeding the IF/ID register and then `id`.
- Owns the PC and reads each 32-bit instruction over an 8-bit synchronous memory port as four byte reads, assembled little-endian.
- Presents {pc_o, inst_o} with a valid flag.
- Honours the ctrl stall bus and branch redirects from EX.

Parameters:
RESET_PC, 32'h0000_0000, PC of the first fetch after reset.

Ports:
clk  input  1  clock, rising edge.
rst  input  1  synchronous, active-high reset (`RstEnable = 1'b1`).
stall_i  input  6  ctrl stall bus; bit0 = hold PC (no new fetch), bit1 = IF/ID hold (output not consumed).
branch_flag_i  input  1  redirect request from EX.
branch_target_i  input  32  redirect PC.
mem_din_i  input  8  read data; returns the byte addressed one cycle earlier.
mem_a_o  output  32  byte address.
mem_re_o  output  1  read enable.
pc_o  output  32  PC of the presented instruction.
inst_o  output  32  assembled instruction.
inst_valid_o  output  1  pc_o/inst_o hold a valid instruction.

Behaviour:
- Reset and clocking
  - One clock, reset synchronous active-high.
  - Reset values: fetch_pc = RESET_PC, state = F0, pc_o = 0, inst_o = 0, inst_valid_o = 0, byte buffer = 0.
  - While rst = 1: mem_re_o = 0 and mem_a_o = 0.
- States: F0, F1, F2, F3, F4, OUT.
  - mem_a_o and mem_re_o are combinational decodes of state and fetch_pc. All other outputs are registered.
- F0
  - If stall_i[0] = 0: mem_re_o = 1, mem_a_o = fetch_pc, next state F1.
  - Otherwise mem_re_o = 0 and the block stays in F0.
- F1, F2, F3
  - Capture the byte for the previous address into b0, b1, b2 respectively.
  - Issue fetch_pc+1, fetch_pc+2, fetch_pc+3 respectively, with mem_re_o = 1.
  - No stall is checked inside F1..F4: an in-flight fetch always completes.
- F4
  - Capture b3 (mem_re_o = 0).
  - Load inst_o = {mem_din_i, b2, b1, b0}, pc_o = fetch_pc, inst_valid_o = 1; next state OUT.
- OUT
  - If stall_i[1] = 0: the instruction is consumed at this edge. fetch_pc += 4, inst_valid_o = 0, next state F0.
  - If stall_i[1] = 1: hold pc_o, inst_o and inst_valid_o unchanged.
- Latency and throughput
  - 5 cycles from F0 issue to inst_valid_o rising.
  - Minimum 6 cycles per instruction.
- Address arithmetic: all adds are modulo 2^32. Example: fetch_pc = 32'hFFFF_FFFE reads FFFF_FFFE, FFFF_FFFF, 0000_0000, 0000_0001.
- Branch redirect (branch_flag_i = 1, any state)
  - Next edge: fetch_pc = branch_target_i, state = F0, inst_valid_o = 0.
  - Captured bytes are discarded, and the byte returned the cycle after the abort is ignored.
  - A completion in F4 on the same edge is discarded.
  - A held OUT instruction is dropped.
- Priority: rst > branch_flag_i > stall_i.
- Reset mid-fetch aborts everything; fetch restarts from RESET_PC in F0 on the cycle after rst falls.

Optional Feature:
IF_MISALIGN_CHK_EN.
- Defined
  - Adds output port inst_misaligned_o (1 bit, reset 0).
  - On a redirect with branch_target_i[1:0] != 2'b00: no memory reads. Next edge goes straight to OUT with pc_o = branch_target_i, inst_o = 32'h0000_0013 (NOP), inst_valid_o = 1, inst_misaligned_o = 1.
  - On consumption: inst_misaligned_o = 0, and fetch resumes at {branch_target_i[31:2], 2'b00} + 4.
  - inst_misaligned_o is 0 for every normal instruction.
- Undefined
  - Port absent, no check.
  - Unaligned targets are fetched byte-wise like any other address.

Decomposition:
- define.v gains: IF state encodings (`IF_F0` .. `IF_OUT`, 3 bits), `StallBus` 5:0, `NopInst` 32'h0000_0013, `MemDataBus` 7:0.
- Reuses `InstAddrBus`, `InstBus`, `RstEnable`, `ZeroWord` from define.v.
- No sub-module; byte assembly is a 24-bit buffer plus a concatenation.

Test Plan:
- Reset fetch: RESET_PC = 0, memory bytes 0..3 = 13,05,00,00. After rst → mem_a_o steps 0,1,2,3 over four cycles; inst_valid_o rises in cycle 5 with inst_o = 32'h0000_0513, pc_o = 0.
- Back-to-back, stall_i = 0: second word at bytes 4..7 = B7,02,01,00 → inst_o = 32'h000102B7, pc_o = 4, 6 cycles after the first valid.
- IF/ID hold: assert stall_i[1] for 3 cycles while in OUT → pc_o, inst_o and valid held for 3 cycles; mem_re_o stays 0; the next fetch's F0 follows release.
- Redirect during F2 to 32'h100 → partial word discarded; next mem_a_o = 32'h100; no valid for the old PC. Also fire the redirect in the same cycle as F4 → completion discarded.
- Wrap: redirect to 32'hFFFF_FFFE → addresses FFFF_FFFE, FFFF_FFFF, 0, 1. With IF_MISALIGN_CHK_EN → NOP presented, pc_o = FFFF_FFFE, inst_misaligned_o = 1; next fetch at 32'h0000_0000 (FFFF_FFFC + 4 mod 2^32).
- rst asserted in F3 → next edge: inst_valid_o = 0, mem_re_o = 0 while rst is high; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/if_fetch_pkg.sv
// ---------------------------------------------------------------------------
// if_fetch_pkg
// Shared constants for the instruction-fetch stage: bus widths, fetch-state
// encodings (3-bit legacy-compatible constants), the NOP encoding and a
// word-alignment helper.
// ---------------------------------------------------------------------------
package if_fetch_pkg;

    localparam int INST_ADDR_W = 32;  // instruction address bus
    localparam int INST_W      = 32;  // instruction bus
    localparam int MEM_DATA_W  = 8;   // byte-wide memory read port
    localparam int STALL_W     = 6;   // ctrl stall bus

    // Stall bus bit positions used by this stage.
    localparam int STALL_PC   = 0;    // hold PC, no new fetch
    localparam int STALL_IFID = 1;    // IF/ID register holding, output not consumed

    localparam logic RST_ENABLE = 1'b1;

    localparam logic [INST_W-1:0]      NOP_INST  = 32'h0000_0013;
    localparam logic [INST_ADDR_W-1:0] ZERO_WORD = 32'h0000_0000;

    // Fetch-state encodings.
    localparam logic [2:0] IF_F0  = 3'd0;  // issue byte 0 (or wait on PC stall)
    localparam logic [2:0] IF_F1  = 3'd1;  // capture byte 0, issue byte 1
    localparam logic [2:0] IF_F2  = 3'd2;  // capture byte 1, issue byte 2
    localparam logic [2:0] IF_F3  = 3'd3;  // capture byte 2, issue byte 3
    localparam logic [2:0] IF_F4  = 3'd4;  // capture byte 3, present word
    localparam logic [2:0] IF_OUT = 3'd5;  // word presented, waiting for consumption

    // Word-aligned version of an address.
    function automatic logic [INST_ADDR_W-1:0] align_word(input logic [INST_ADDR_W-1:0] addr);
        return {addr[INST_ADDR_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_fetch.sv
// ---------------------------------------------------------------------------
// if_fetch
// Instruction-fetch stage feeding the IF/ID register. Owns the PC and reads
// each 32-bit instruction as four sequential byte reads over an 8-bit
// synchronous memory port (data returns one cycle after the address),
// assembling the word little-endian. Honours the ctrl stall bus and branch
// redirects from EX. Priority: rst > branch_flag_i > stall_i.
//
// Optional build macro: IF_MISALIGN_CHK_EN
//   When defined, a redirect to a non-word-aligned target performs no memory
//   reads; a NOP is presented at the target PC with inst_misaligned_o = 1,
//   and fetch resumes at the aligned target + 4 once it is consumed.
//
// Parameters:
//   RESET_PC         PC of the first fetch after reset
// Ports:
//   clk              clock, rising edge
//   rst              synchronous active-high reset
//   stall_i[5:0]     bit0 = hold PC, bit1 = IF/ID hold (others unused here)
//   branch_flag_i    redirect request from EX
//   branch_target_i  redirect PC
//   mem_din_i[7:0]   byte read data for the address issued one cycle earlier
//   mem_a_o[31:0]    byte address (combinational)
//   mem_re_o         read enable (combinational)
//   pc_o[31:0]       PC of the presented instruction
//   inst_o[31:0]     assembled instruction
//   inst_valid_o     pc_o/inst_o hold a valid instruction
//   inst_misaligned_o  (IF_MISALIGN_CHK_EN only) presented NOP stands in for
//                      a misaligned redirect target
// ---------------------------------------------------------------------------
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter logic [INST_ADDR_W-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [STALL_W-1:0]     stall_i,
    input  logic                   branch_flag_i,
    input  logic [INST_ADDR_W-1:0] branch_target_i,
    input  logic [MEM_DATA_W-1:0]  mem_din_i,
    output logic [INST_ADDR_W-1:0] mem_a_o,
    output logic                   mem_re_o,
    output logic [INST_ADDR_W-1:0] pc_o,
    output logic [INST_W-1:0]      inst_o,
    output logic                   inst_valid_o
`ifdef IF_MISALIGN_CHK_EN
    ,
    output logic                   inst_misaligned_o
`endif
);

    logic [2:0]             state;
    logic [INST_ADDR_W-1:0] fetch_pc;
    logic [23:0]            byte_buf;   // b2:b1:b0, b3 comes straight from mem_din_i

    // Only the two low stall bits concern this stage.
    logic unused_stall;
    assign unused_stall = ^stall_i[STALL_W-1:2];

    // -----------------------------------------------------------------------
    // Memory request decode
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // no path leaves it unassigned and no latch is inferred.
        mem_re_o = 1'b0;
        mem_a_o  = ZERO_WORD;
        if (rst != RST_ENABLE) begin
            case (state)
                IF_F0: begin
                    mem_a_o  = fetch_pc;
                    mem_re_o = ~stall_i[STALL_PC];
                end
                IF_F1: begin
                    mem_a_o  = fetch_pc + 32'd1;
                    mem_re_o = 1'b1;
                end
                IF_F2: begin
                    mem_a_o  = fetch_pc + 32'd2;
                    mem_re_o = 1'b1;
                end
                IF_F3: begin
                    mem_a_o  = fetch_pc + 32'd3;
                    mem_re_o = 1'b1;
                end
                default: begin
                    mem_a_o  = ZERO_WORD;
                    mem_re_o = 1'b0;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Fetch sequencer and output register
    // -----------------------------------------------------------------------
    // NOTE: state is updated with non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            state        <= IF_F0;
            fetch_pc     <= RESET_PC;
            byte_buf     <= '0;
            pc_o         <= ZERO_WORD;
            inst_o       <= '0;
            inst_valid_o <= 1'b0;
`ifdef IF_MISALIGN_CHK_EN
            inst_misaligned_o <= 1'b0;
`endif
        end else if (branch_flag_i) begin
            // Redirect aborts any in-flight fetch (including an F4 completion
            // on this edge) and drops a held instruction. The byte returning
            // next cycle is ignored because F0 never captures.
            byte_buf <= '0;
`ifdef IF_MISALIGN_CHK_EN
            if (branch_target_i[1:0] != 2'b00) begin
                // Present a NOP for the bad target; fetch_pc keeps the aligned
                // base so consumption resumes at aligned target + 4.
                state             <= IF_OUT;
                fetch_pc          <= align_word(branch_target_i);
                pc_o              <= branch_target_i;
                inst_o            <= NOP_INST;
                inst_valid_o      <= 1'b1;
                inst_misaligned_o <= 1'b1;
            end else begin
                state             <= IF_F0;
                fetch_pc          <= branch_target_i;
                inst_valid_o      <= 1'b0;
                inst_misaligned_o <= 1'b0;
            end
`else
            state        <= IF_F0;
            fetch_pc     <= branch_target_i;
            inst_valid_o <= 1'b0;
`endif
        end else begin
            case (state)
                IF_F0: begin
                    if (!stall_i[STALL_PC]) begin
                        state <= IF_F1;
                    end
                end
                IF_F1: begin
                    byte_buf[7:0] <= mem_din_i;
                    state         <= IF_F2;
                end
                IF_F2: begin
                    byte_buf[15:8] <= mem_din_i;
                    state          <= IF_F3;
                end
                IF_F3: begin
                    byte_buf[23:16] <= mem_din_i;
                    state           <= IF_F4;
                end
                IF_F4: begin
                    inst_o       <= {mem_din_i, byte_buf};
                    pc_o         <= fetch_pc;
                    inst_valid_o <= 1'b1;
                    state        <= IF_OUT;
                end
                IF_OUT: begin
                    if (!stall_i[STALL_IFID]) begin
                        fetch_pc     <= fetch_pc + 32'd4;
                        inst_valid_o <= 1'b0;
`ifdef IF_MISALIGN_CHK_EN
                        inst_misaligned_o <= 1'b0;
`endif
                        state        <= IF_F0;
                    end
                end
                default: begin
                    state        <= IF_F0;
                    inst_valid_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_if_fetch.sv
// ---------------------------------------------------------------------------
// tb_if_fetch
// Self-checking bench for if_fetch: directed steps for reset, back-to-back
// fetch, IF/ID hold, redirects in F2 and F4, address wrap (and the misaligned
// NOP path when IF_MISALIGN_CHK_EN is defined), reset mid-fetch, followed by
// a randomized stall/redirect phase checked against a transaction-level
// model (expected PC sequence + byte-addressed memory contents).
// ---------------------------------------------------------------------------
module tb_if_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall;
    logic        br;
    logic [31:0] tgt;
    logic [7:0]  mem_din;
    logic [31:0] mem_a;
    logic        mem_re;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        valid;
`ifdef IF_MISALIGN_CHK_EN
    logic        misaligned;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    if_fetch #(.RESET_PC(32'h0000_0000)) dut (
        .clk             (clk),
        .rst             (rst),
        .stall_i         (stall),
        .branch_flag_i   (br),
        .branch_target_i (tgt),
        .mem_din_i       (mem_din),
        .mem_a_o         (mem_a),
        .mem_re_o        (mem_re),
        .pc_o            (pc),
        .inst_o          (inst),
        .inst_valid_o    (valid)
`ifdef IF_MISALIGN_CHK_EN
        ,
        .inst_misaligned_o (misaligned)
`endif
    );

    // Memory contents: the test-plan bytes at 0..7, a hash elsewhere.
    function automatic logic [7:0] mem_byte(input logic [31:0] a);
        case (a)
            32'd0:   return 8'h13;
            32'd1:   return 8'h05;
            32'd2:   return 8'h00;
            32'd3:   return 8'h00;
            32'd4:   return 8'hB7;
            32'd5:   return 8'h02;
            32'd6:   return 8'h01;
            32'd7:   return 8'h00;
            default: return a[7:0] ^ a[15:8] ^ a[23:16] ^ a[31:24] ^ 8'h5A ^ {a[3:0], a[7:4]};
        endcase
    endfunction

    // Little-endian 32-bit word at byte address a, wrapping modulo 2^32.
    function automatic logic [31:0] word_at(input logic [31:0] a);
        return {mem_byte(a + 32'd3), mem_byte(a + 32'd2), mem_byte(a + 32'd1), mem_byte(a)};
    endfunction

    // Synchronous byte memory: data for the address seen at this edge
    // appears after it; garbage when not reading.
    always @(posedge clk) begin
        if (mem_re) mem_din <= mem_byte(mem_a);
        else        mem_din <= 8'($urandom);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] exp_pc;
        int          presented;

        rst = 1'b1; stall = 6'd0; br = 1'b0; tgt = 32'd0;

        // ---------------- reset state ----------------
        cyc(2);
        check("rst_re",    {31'd0, mem_re}, 32'd0);
        check("rst_a",     mem_a, 32'd0);
        check("rst_valid", {31'd0, valid}, 32'd0);
        check("rst_pc",    pc, 32'd0);
        check("rst_inst",  inst, 32'd0);

        // ---------------- first fetch from RESET_PC ----------------
        rst = 1'b0;
        #1;
        check("f_a0",  mem_a, 32'd0);
        check("f_re0", {31'd0, mem_re}, 32'd1);
        for (int i = 1; i < 4; i++) begin
            cyc();
            check($sformatf("f_a%0d", i), mem_a, 32'(i));
            check($sformatf("f_re%0d", i), {31'd0, mem_re}, 32'd1);
        end
        cyc();
        check("f4_re",    {31'd0, mem_re}, 32'd0);
        check("f4_valid", {31'd0, valid}, 32'd0);
        cyc();
        check("first_valid", {31'd0, valid}, 32'd1);
        check("first_inst",  inst, 32'h0000_0513);
        check("first_pc",    pc, 32'd0);

        // ---------------- back-to-back: 6 cycles per word ----------------
        cyc(5);
        check("b2b_gap_valid", {31'd0, valid}, 32'd0);
        cyc();
        check("b2b_valid", {31'd0, valid}, 32'd1);
        check("b2b_inst",  inst, 32'h0001_02B7);
        check("b2b_pc",    pc, 32'd4);

        // ---------------- IF/ID hold for 3 cycles ----------------
        stall = 6'b000010;
        for (int i = 0; i < 3; i++) begin
            cyc();
            check($sformatf("hold%0d_valid", i), {31'd0, valid}, 32'd1);
            check($sformatf("hold%0d_pc", i),    pc, 32'd4);
            check($sformatf("hold%0d_inst", i),  inst, 32'h0001_02B7);
            check($sformatf("hold%0d_re", i),    {31'd0, mem_re}, 32'd0);
        end
        stall = 6'd0;
        cyc();
        check("rel_a",     mem_a, 32'd8);
        check("rel_re",    {31'd0, mem_re}, 32'd1);
        check("rel_valid", {31'd0, valid}, 32'd0);

        // ---------------- redirect during F2 ----------------
        cyc(2);
        check("f2_a", mem_a, 32'd10);
        br = 1'b1; tgt = 32'h0000_0100;
        cyc();
        br = 1'b0;
        check("redir_a",     mem_a, 32'h0000_0100);
        check("redir_re",    {31'd0, mem_re}, 32'd1);
        check("redir_valid", {31'd0, valid}, 32'd0);
        cyc(4);
        check("redir_f4_valid", {31'd0, valid}, 32'd0);
        cyc();
        check("redir_valid_up", {31'd0, valid}, 32'd1);
        check("redir_pc",       pc, 32'h0000_0100);
        check("redir_inst",     inst, word_at(32'h0000_0100));

        // ---------------- redirect coincident with F4 ----------------
        cyc();
        check("f4r_f0_a", mem_a, 32'h0000_0104);
        cyc(4);
        check("f4r_re", {31'd0, mem_re}, 32'd0);
        br = 1'b1; tgt = 32'h0000_0200;
        cyc();
        br = 1'b0;
        check("f4r_valid", {31'd0, valid}, 32'd0);
        check("f4r_a",     mem_a, 32'h0000_0200);
        cyc(4);
        check("f4r_f4_valid", {31'd0, valid}, 32'd0);
        cyc();
        check("f4r_valid_up", {31'd0, valid}, 32'd1);
        check("f4r_pc",       pc, 32'h0000_0200);
        check("f4r_inst",     inst, word_at(32'h0000_0200));

        // ---------------- wrap / misaligned redirect ----------------
        br = 1'b1; tgt = 32'hFFFF_FFFE;
        cyc();
        br = 1'b0;
`ifdef IF_MISALIGN_CHK_EN
        check("mis_valid", {31'd0, valid}, 32'd1);
        check("mis_pc",    pc, 32'hFFFF_FFFE);
        check("mis_inst",  inst, 32'h0000_0013);
        check("mis_flag",  {31'd0, misaligned}, 32'd1);
        check("mis_re",    {31'd0, mem_re}, 32'd0);
        stall = 6'b000010;
        cyc();
        check("mis_hold_flag", {31'd0, misaligned}, 32'd1);
        stall = 6'd0;
        cyc();
        check("mis_next_a",     mem_a, 32'h0000_0000);
        check("mis_next_flag",  {31'd0, misaligned}, 32'd0);
        check("mis_next_valid", {31'd0, valid}, 32'd0);
        cyc(5);
        check("mis_after_pc",   pc, 32'h0000_0000);
        check("mis_after_inst", inst, 32'h0000_0513);
        check("mis_after_flag", {31'd0, misaligned}, 32'd0);
`else
        check("wrap_a0", mem_a, 32'hFFFF_FFFE);
        check("wrap_re", {31'd0, mem_re}, 32'd1);
        cyc();
        check("wrap_a1", mem_a, 32'hFFFF_FFFF);
        cyc();
        check("wrap_a2", mem_a, 32'h0000_0000);
        cyc();
        check("wrap_a3", mem_a, 32'h0000_0001);
        cyc(2);
        check("wrap_valid", {31'd0, valid}, 32'd1);
        check("wrap_pc",    pc, 32'hFFFF_FFFE);
        check("wrap_inst",  inst, word_at(32'hFFFF_FFFE));
        cyc();
        check("wrap_next_a", mem_a, 32'h0000_0002);
        cyc(5);
        check("wrap_after_pc",   pc, 32'h0000_0002);
        check("wrap_after_inst", inst, word_at(32'h0000_0002));
`endif

        // ---------------- reset asserted in F3 ----------------
        cyc(4);
        check("pre_rst_re", {31'd0, mem_re}, 32'd1);
        rst = 1'b1;
        cyc();
        check("mrst_valid", {31'd0, valid}, 32'd0);
        check("mrst_re",    {31'd0, mem_re}, 32'd0);
        check("mrst_a",     mem_a, 32'd0);
        cyc();
        check("mrst_re2",   {31'd0, mem_re}, 32'd0);
        rst = 1'b0;
        #1;
        check("mrst_restart_a",  mem_a, 32'd0);
        check("mrst_restart_re", {31'd0, mem_re}, 32'd1);
        cyc(5);
        check("mrst_valid_up", {31'd0, valid}, 32'd1);
        check("mrst_pc",       pc, 32'd0);
        check("mrst_inst",     inst, 32'h0000_0513);

        // ---------------- randomized stalls and redirects ----------------
        // Transaction model: the presented instruction is always the word at
        // the expected PC; consumption advances it by 4, a redirect replaces it.
        exp_pc    = 32'd0;
        presented = 0;
        repeat (3000) begin
            if (valid) begin
                presented++;
                check("rnd_pc",   pc, exp_pc);
                check("rnd_inst", inst, word_at(exp_pc));
                check("rnd_re",   {31'd0, mem_re}, 32'd0);
`ifdef IF_MISALIGN_CHK_EN
                check("rnd_mis",  {31'd0, misaligned}, 32'd0);
`endif
            end
            stall = (6'($urandom) & 6'b111100)
                  | (($urandom_range(0, 3) == 0) ? 6'b000001 : 6'b000000)
                  | (($urandom_range(0, 2) == 0) ? 6'b000010 : 6'b000000);
            br  = ($urandom_range(0, 24) == 0);
            tgt = $urandom;
`ifdef IF_MISALIGN_CHK_EN
            tgt[1:0] = 2'b00;
`endif
            if (br)                      exp_pc = tgt;
            else if (valid && !stall[1]) exp_pc = exp_pc + 32'd4;
            cyc();
        end
        br = 1'b0; stall = 6'd0;
        check("rnd_progress", {31'd0, presented > 100}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
